// File: rtl/lc3_pipe_ctrl.sv
// rtl/lc3_pipe_ctrl.sv - LC-3 pipeline control FSM (fill/run/mem/branch) with registered enables.
// Define LC3_PIPE_CTRL_BYPASS_EN for operand bypass outputs; otherwise hazards insert a one-cycle stall.
module lc3_pipe_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state
);
    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                           OP_ST  = 4'b0011, OP_AND = 4'b0101, OP_LDR = 4'b0110,
                           OP_STR = 4'b0111, OP_NOT = 4'b1001, OP_LDI = 4'b1010,
                           OP_STI = 4'b1011, OP_JMP = 4'b1100;

    typedef enum logic [1:0] {S_FILL, S_RUN, S_MEM, S_BRANCH} state_t;

    state_t     state, state_nxt;
    logic [1:0] b_cnt, b_cnt_nxt;
    logic       st_seq, st_seq_nxt;

    logic       fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt, br_nxt;
    logic [1:0] mem_nxt;
    logic [3:0] byp_nxt;

    logic [3:0] op_d, op_x;
    logic       x_alu, x_load, x_store, d_alu, d_alu_reg, d_branch;
    logic       src1_hit, src2_hit, br_cond;
    logic       haz_alu_1, haz_alu_2, haz_mem_1, haz_mem_2;
    logic       mem_entry, br_entry, stall_entry;
    logic [1:0] mem_first, mem_step;
    logic       unused_bits;

    assign op_d        = IR[15:12];
    assign op_x        = IR_Exec[15:12];
    assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

    assign x_alu     = (op_x == OP_ADD) || (op_x == OP_AND) || (op_x == OP_NOT);
    assign x_load    = (op_x == OP_LD) || (op_x == OP_LDR) || (op_x == OP_LDI);
    assign x_store   = (op_x == OP_ST) || (op_x == OP_STR) || (op_x == OP_STI);
    assign d_alu     = (op_d == OP_ADD) || (op_d == OP_AND) || (op_d == OP_NOT);
    assign d_alu_reg = ((op_d == OP_ADD) || (op_d == OP_AND)) && !IR[5];
    assign d_branch  = (op_d == OP_BR) || (op_d == OP_JMP);
    assign src1_hit  = (IR[8:6] == IR_Exec[11:9]);
    assign src2_hit  = (IR[2:0] == IR_Exec[11:9]);
    assign br_cond   = (op_x == OP_JMP) || (|(NZP & psr));

    assign haz_alu_1 = x_alu  && d_alu     && src1_hit;
    assign haz_alu_2 = x_alu  && d_alu_reg && src2_hit;
    assign haz_mem_1 = x_load && d_alu     && src1_hit;
    assign haz_mem_2 = x_load && d_alu_reg && src2_hit;

    // Memory entry outranks branch entry, which outranks a hazard stall.
    assign mem_entry = (state == S_RUN) && enable_execute && (x_load || x_store);
    assign br_entry  = (state == S_RUN) && enable_decode && d_branch;
`ifdef LC3_PIPE_CTRL_BYPASS_EN
    assign stall_entry = 1'b0;
`else
    assign stall_entry = (state == S_RUN) && enable_decode &&
                         (haz_alu_1 || haz_alu_2 || haz_mem_1 || haz_mem_2);
`endif

    always_comb begin
        case (op_x)
            OP_LD, OP_LDR:  mem_first = 2'd0;
            OP_LDI, OP_STI: mem_first = 2'd1;
            default:        mem_first = 2'd2;
        endcase
    end

    // Indirect accesses fetch the pointer (1) before the final read or write.
    always_comb begin
        case (mem_state)
            2'd1:    mem_step = st_seq ? 2'd2 : 2'd0;
            default: mem_step = 2'd3;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_FILL;
            b_cnt            <= 2'd0;
            st_seq           <= 1'b0;
            enable_fetch     <= 1'b1;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            enable_updatePC  <= 1'b1;
            br_taken         <= 1'b0;
            mem_state        <= 2'd3;
            {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} <= 4'b0000;
        end else begin
            state            <= state_nxt;
            b_cnt            <= b_cnt_nxt;
            st_seq           <= st_seq_nxt;
            enable_fetch     <= fetch_nxt;
            enable_decode    <= decode_nxt;
            enable_execute   <= execute_nxt;
            enable_writeback <= writeback_nxt;
            enable_updatePC  <= updpc_nxt;
            br_taken         <= br_nxt;
            mem_state        <= mem_nxt;
            {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} <= byp_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        b_cnt_nxt  = b_cnt;
        st_seq_nxt = st_seq;
        case (state)
            S_FILL: if (enable_decode && enable_execute) state_nxt = S_RUN;
            S_RUN: begin
                if (mem_entry) begin
                    state_nxt  = S_MEM;
                    st_seq_nxt = x_store;
                end else if (br_entry) begin
                    state_nxt = S_BRANCH;
                    b_cnt_nxt = 2'd0;
                end
            end
            S_MEM: if (complete_data && (mem_step == 2'd3)) state_nxt = S_RUN;
            default: begin
                if (b_cnt == 2'd2) state_nxt = S_RUN;
                else               b_cnt_nxt = b_cnt + 2'd1;
            end
        endcase
    end

    always_comb begin
        fetch_nxt     = enable_fetch;
        decode_nxt    = enable_decode;
        execute_nxt   = enable_execute;
        writeback_nxt = enable_writeback;
        updpc_nxt     = enable_updatePC;
        br_nxt        = 1'b0;
        mem_nxt       = mem_state;
        case (state)
            S_FILL: begin
                fetch_nxt     = 1'b1;
                updpc_nxt     = 1'b1;
                decode_nxt    = 1'b1;
                execute_nxt   = enable_decode;
                writeback_nxt = enable_execute;
                mem_nxt       = 2'd3;
            end
            S_RUN: begin
                mem_nxt = 2'd3;
                if (mem_entry) begin
                    {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b00000;
                    mem_nxt = mem_first;
                end else if (br_entry || stall_entry) begin
                    {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b00110;
                end else begin
                    {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b11111;
                end
            end
            S_MEM: begin
                if (complete_data) begin
                    mem_nxt = mem_step;
                    if (mem_step == 2'd3)
                        {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b11111;
                end
            end
            default: begin
                mem_nxt = 2'd3;
                case (b_cnt)
                    2'd0: {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b00110;
                    2'd1: begin
                        {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b10111;
                        br_nxt = br_cond;
                    end
                    default: {fetch_nxt, decode_nxt, execute_nxt, writeback_nxt, updpc_nxt} = 5'b11111;
                endcase
            end
        endcase
`ifdef LC3_PIPE_CTRL_BYPASS_EN
        byp_nxt = {haz_alu_1, haz_alu_2, haz_mem_1, haz_mem_2} & {4{execute_nxt}};
`else
        byp_nxt = 4'b0000;
`endif
    end
endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// tb/tb_lc3_pipe_ctrl.sv - directed vector table plus randomized run against a queue-based reference model.
module tb_lc3_pipe_ctrl;
    logic        clock = 1'b0;
    logic        reset, complete_data;
    logic [15:0] IR, IR_Exec;
    logic [2:0]  NZP, psr;
    logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
    logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0]  mem_state;
    logic [11:0] act;

    int checks = 0;
    int errors = 0;

    lc3_pipe_ctrl dut (
        .clock(clock), .reset(reset), .complete_data(complete_data),
        .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .mem_state(mem_state)
    );

    always #5 clock = ~clock;

    // {fetch, decode, execute, writeback, updatePC, br_taken, alu1, alu2, mem1, mem2, mem_state}
    assign act = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
                  br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state};

    localparam logic [11:0] RST_V = 12'b1_0_0_0_1_0_0000_11;
    localparam logic [11:0] D1    = 12'b1_1_0_0_1_0_0000_11;
    localparam logic [11:0] D2    = 12'b1_1_1_0_1_0_0000_11;
    localparam logic [11:0] ALL   = 12'b1_1_1_1_1_0_0000_11;
    localparam logic [11:0] ALLB  = 12'b1_1_1_1_1_0_1100_11;
    localparam logic [11:0] STL   = 12'b0_0_1_1_0_0_0000_11;
    localparam logic [11:0] M0    = 12'b0_0_0_0_0_0_0000_00;
    localparam logic [11:0] M1    = 12'b0_0_0_0_0_0_0000_01;
    localparam logic [11:0] M2    = 12'b0_0_0_0_0_0_0000_10;
    localparam logic [11:0] B01   = 12'b0_0_1_1_0_0_0000_11;
    localparam logic [11:0] B2T   = 12'b1_0_1_1_1_1_0000_11;
    localparam logic [11:0] B2N   = 12'b1_0_1_1_1_0_0000_11;
    localparam logic [15:0] NOP   = 16'hE000;

    typedef struct {
        logic        rst;
        logic        cd;
        logic [15:0] ir;
        logic [15:0] irx;
        logic [2:0]  nzp;
        logic [2:0]  ps;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic cd, input logic [15:0] ir, input logic [15:0] irx,
                       input logic [2:0] nzp, input logic [2:0] ps, input logic [11:0] exp);
        vec_t v;
        v = '{rst, cd, ir, irx, nzp, ps, exp};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b", name, idx, got, want);
        end
    endtask

    // Reference model: current expected outputs plus phase bookkeeping.
    logic [11:0] m;
    int          fill_n;
    int          mq[$];
    int          br_ph;

    function automatic bit is_alu(input logic [3:0] o);
        return o == 4'h1 || o == 4'h5 || o == 4'h9;
    endfunction
    function automatic bit is_load(input logic [3:0] o);
        return o == 4'h2 || o == 4'h6 || o == 4'hA;
    endfunction
    function automatic bit is_store(input logic [3:0] o);
        return o == 4'h3 || o == 4'h7 || o == 4'hB;
    endfunction

    task automatic model_step(input logic rst, input logic cd, input logic [15:0] ir,
                              input logic [15:0] irx, input logic [2:0] nzp, input logic [2:0] ps);
        logic [4:0] en;
        logic       bt;
        int         ms;
        logic [3:0] haz;
        logic [3:0] od, ox;
        od = ir[15:12];
        ox = irx[15:12];
        haz[3] = is_alu(ox)  && is_alu(od) && ir[8:6] == irx[11:9];
        haz[2] = is_alu(ox)  && (od == 4'h1 || od == 4'h5) && !ir[5] && ir[2:0] == irx[11:9];
        haz[1] = is_load(ox) && is_alu(od) && ir[8:6] == irx[11:9];
        haz[0] = is_load(ox) && (od == 4'h1 || od == 4'h5) && !ir[5] && ir[2:0] == irx[11:9];
        bt = 1'b0;
        ms = 3;
        if (rst) begin
            en = 5'b10001;
            fill_n = 0;
            mq.delete();
            br_ph = -1;
        end else if (fill_n < 3) begin
            fill_n++;
            en = {1'b1, 1'b1, fill_n >= 2, fill_n >= 3, 1'b1};
        end else if (mq.size() > 0) begin
            en = 5'b00000;
            if (cd) void'(mq.pop_front());
            ms = mq[0];
            if (ms == 3) begin
                en = 5'b11111;
                mq.delete();
            end
        end else if (br_ph >= 0) begin
            br_ph++;
            if (br_ph == 1) en = 5'b00110;
            else if (br_ph == 2) begin
                en = 5'b10111;
                bt = (ox == 4'hC) || (|(nzp & ps));
            end else begin
                en = 5'b11111;
                br_ph = -1;
            end
        end else begin
            if (m[9] && (is_load(ox) || is_store(ox))) begin
                case (ox)
                    4'h2, 4'h6: mq = '{0, 3};
                    4'hA:       mq = '{1, 0, 3};
                    4'h3, 4'h7: mq = '{2, 3};
                    default:    mq = '{1, 2, 3};
                endcase
                en = 5'b00000;
                ms = mq[0];
            end else if (m[10] && (od == 4'h0 || od == 4'hC)) begin
                br_ph = 0;
                en = 5'b00110;
`ifndef LC3_PIPE_CTRL_BYPASS_EN
            end else if (m[10] && (|haz)) begin
                en = 5'b00110;
`endif
            end else begin
                en = 5'b11111;
            end
        end
`ifdef LC3_PIPE_CTRL_BYPASS_EN
        if (!en[2]) haz = 4'b0000;
`else
        haz = 4'b0000;
`endif
        m = {en, bt, haz, 2'(ms)};
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        logic [1:0] r1, r2, r3;
        logic       imm;
        case ($urandom_range(0, 11))
            0: op = 4'h1;  1: op = 4'h5;  2: op = 4'h9;  3: op = 4'h0;
            4: op = 4'hC;  5: op = 4'h2;  6: op = 4'h6;  7: op = 4'hA;
            8: op = 4'hE;  9: op = 4'h3; 10: op = 4'h7; default: op = 4'hB;
        endcase
        r1  = 2'($urandom_range(0, 3));
        r2  = 2'($urandom_range(0, 3));
        r3  = 2'($urandom_range(0, 3));
        imm = 1'($urandom_range(0, 1));
        return {op, 1'b0, r1, 1'b0, r2, imm, 2'b00, 1'b0, r3};
    endfunction

    initial begin
        reset = 1'b1; complete_data = 1'b0; IR = NOP; IR_Exec = NOP; NZP = 3'd0; psr = 3'd0;
        m = RST_V; fill_n = 0; br_ph = -1;

        add(1, 0, NOP, NOP, 0, 0, RST_V);
        add(1, 0, NOP, NOP, 0, 0, RST_V);
        add(0, 0, NOP, NOP, 0, 0, D1);
        add(0, 0, NOP, NOP, 0, 0, D2);
        add(0, 0, NOP, NOP, 0, 0, ALL);
        add(0, 0, NOP, NOP, 0, 0, ALL);
`ifdef LC3_PIPE_CTRL_BYPASS_EN
        add(0, 0, 16'h1841, 16'h1283, 0, 0, ALLB);
        add(0, 0, 16'h1841, 16'h1283, 0, 0, ALLB);
`else
        add(0, 0, 16'h1841, 16'h1283, 0, 0, STL);
        add(0, 0, 16'h1841, 16'h1283, 0, 0, ALL);
`endif
        add(0, 0, NOP, NOP, 0, 0, ALL);
        add(0, 1, NOP, 16'hA200, 0, 0, M1);
        add(0, 1, NOP, 16'hA200, 0, 0, M0);
        add(0, 1, NOP, NOP, 0, 0, ALL);
        add(0, 1, NOP, NOP, 0, 0, ALL);
        add(0, 0, NOP, 16'hB200, 0, 0, M1);
        add(0, 0, NOP, 16'hB200, 0, 0, M1);
        add(0, 0, NOP, 16'hB200, 0, 0, M1);
        add(0, 0, NOP, 16'hB200, 0, 0, M1);
        add(0, 1, NOP, 16'hB200, 0, 0, M2);
        add(0, 1, NOP, NOP, 0, 0, ALL);
        add(0, 0, NOP, NOP, 0, 0, ALL);
        add(0, 0, 16'h0405, NOP, 3'b010, 3'b010, B01);
        add(0, 0, 16'h0405, NOP, 3'b010, 3'b010, B01);
        add(0, 0, 16'h0405, NOP, 3'b010, 3'b010, B2T);
        add(0, 0, NOP, NOP, 3'b010, 3'b010, ALL);
        add(0, 0, 16'h0405, NOP, 3'b010, 3'b100, B01);
        add(0, 0, 16'h0405, NOP, 3'b010, 3'b100, B01);
        add(0, 0, 16'h0405, NOP, 3'b010, 3'b100, B2N);
        add(0, 0, NOP, NOP, 3'b010, 3'b100, ALL);
        add(0, 1, NOP, 16'h2200, 0, 0, M0);
        add(1, 1, NOP, 16'h2200, 0, 0, RST_V);
        add(0, 0, NOP, NOP, 0, 0, D1);
        add(0, 0, NOP, NOP, 0, 0, D2);
        add(0, 0, NOP, NOP, 0, 0, ALL);
        add(0, 0, 16'h0405, 16'h2200, 3'b111, 3'b111, M0);
        add(0, 0, 16'h0405, 16'h2200, 3'b111, 3'b111, M0);
        add(0, 1, NOP, NOP, 0, 0, ALL);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; complete_data = tbl[i].cd; IR = tbl[i].ir;
            IR_Exec = tbl[i].irx; NZP = tbl[i].nzp; psr = tbl[i].ps;
            @(posedge clock); #1;
            check("vec", i, act, tbl[i].exp);
        end

        for (int i = 0; i < 3000; i++) begin
            reset         = (i < 2) || ($urandom_range(0, 99) < 2);
            complete_data = 1'($urandom_range(0, 1));
            IR            = rand_instr();
            IR_Exec       = rand_instr();
            NZP           = 3'($urandom_range(0, 7));
            psr           = 3'($urandom_range(0, 7));
            model_step(reset, complete_data, IR, IR_Exec, NZP, psr);
            @(posedge clock); #1;
            check("rand", i, act, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc3_pipe_ctrl.md
LC3_PIPE_CTRL -- requirements
Module: lc3_pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports: clock in 1 (all state on rising edge), reset in 1 (synchronous, active-high).
REQ-002 Inputs SHALL be: complete_data in 1 (memory access done); IR in 16 (decode-stage instruction); IR_Exec in 16 (execute-stage instruction); NZP in 3 (branch condition field of IR_Exec); psr in 3 (current condition codes).
REQ-003 Outputs SHALL be: enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2 (each out 1); mem_state out 2 (0 read, 1 indirect read, 2 write, 3 idle).
REQ-004 Opcodes SHALL be IR[15:12]: ADD 0001, AND 0101, NOT 1001, BR 0000, JMP 1100, LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011.

Function
REQ-005 Controller SHALL be an FSM with states FILL, RUN, MEM, BRANCH; all outputs registered.
REQ-006 FILL: cycle 1 after reset release sets enable_decode=1, cycle 2 enable_execute=1, cycle 3 enable_writeback=1, then RUN; enables once set stay high within FILL.
REQ-007 RUN: all five enables 1, mem_state=3, br_taken=0.
REQ-008 RUN->MEM when enable_execute=1 and IR_Exec opcode is LD/LDR/LDI/ST/STR/STI; next cycle all five enables 0.
REQ-009 MEM sequences: LD/LDR 0->3; LDI 1->0->3; ST/STR 2->3; STI 1->2->3; each step advances only on a cycle with complete_data=1, otherwise holds.
REQ-010 When mem_state returns to 3, the same registered update SHALL restore all five enables to 1 and return to RUN.
REQ-011 RUN->BRANCH when enable_decode=1 and IR opcode is BR or JMP; BRANCH lasts exactly 3 cycles B0,B1,B2.
REQ-012 B0,B1: enable_fetch=0, enable_updatePC=0, enable_decode=0; execute/writeback stay 1.
REQ-013 B2: enable_updatePC=1, br_taken=1 if IR_Exec is JMP or |(NZP & psr) for BR, else 0; next cycle RUN with br_taken=0.
REQ-014 Memory entry SHALL take priority over branch entry on the same cycle; branch detection is suppressed in MEM and FILL and re-evaluated in RUN.
REQ-015 bypass_alu_1 SHALL be 1 when IR_Exec is ADD/AND/NOT, IR is ADD/AND/NOT, and IR[8:6]==IR_Exec[11:9].
REQ-016 bypass_alu_2 SHALL be 1 when IR_Exec is ADD/AND/NOT, IR is ADD/AND with IR[5]=0, and IR[2:0]==IR_Exec[11:9].
REQ-017 bypass_mem_1/bypass_mem_2 SHALL use the REQ-015/016 conditions with IR_Exec being LD/LDR/LDI instead of an ALU op.
REQ-018 Bypass outputs SHALL be forced to 0 whenever enable_execute=0.

Reset
REQ-019 On reset: enable_fetch=1, enable_updatePC=1, all other enables 0, mem_state=3, br_taken=0, all bypass 0, state FILL.
REQ-020 Reset asserted mid-MEM or mid-BRANCH SHALL abandon the sequence and apply REQ-019 on the next edge.

Configuration
REQ-021 Macro LC3_PIPE_CTRL_BYPASS_EN defined: bypass outputs per REQ-015..018.
REQ-022 Macro undefined: bypass outputs tied 0; any condition of REQ-015..017 in RUN instead inserts one stall cycle with enable_fetch, enable_decode, enable_updatePC=0.

Verification
REQ-023 Reset 2 cycles then release -> decode=1 at +1, execute=1 at +2, writeback=1 at +3, mem_state=3 throughout.
REQ-024 IR_Exec=ADD R1,R2,R3 (0x1283), IR=ADD R4,R1,R1 (0x1841) -> bypass_alu_1=1, bypass_alu_2=1 (macro on); one stall cycle (macro off).
REQ-025 IR_Exec=LDI (0xA200), complete_data=1 every cycle -> mem_state 1,0,3, enables 0 for two cycles, restored with mem_state=3.
REQ-026 IR_Exec=STI, complete_data low for 3 cycles -> mem_state holds 1 for 4 cycles, then 2, then 3.
REQ-027 IR=BR z (0x0405), NZP=010, psr=010 -> B0,B1 fetch=0; B2 enable_updatePC=1, br_taken=1; with psr=100 br_taken=0.
REQ-028 Reset asserted while mem_state=0 -> next cycle mem_state=3, enable_fetch=1, enable_decode=0.
